data_bus_responder: RTL
=======================

# data_bus_responder

Data-bus responder for the single-cycle LEGv8 core: the target end of the Dw bus (read/write enables, byte enables, 32-bit address, write data, read data). It owns the data RAM for one address window. Writes go into a posted write buffer and are retired into a single-port word array during idle bus cycles. Reads return same-cycle data, merged with any pending buffered writes to the same word.

## Interface
- BASE_ADDR, 32'h1001_0000, byte address of word 0 of the window.
- ADDR_W, 10, word-address width; window holds 2^ADDR_W 32-bit words.
- WBUF_DEPTH, 4, write-buffer entries; power of two, at least 2.
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iDwReadEnable  in  1  read request this cycle.
- iDwWriteEnable  in  1  write request this cycle.
- iDwByteEnable  in  4  byte lanes; bit n covers data[8n+7:8n].
- iDwAddress  in  32  byte address; bits [1:0] are ignored.
- iDwWriteData  in  32  write data.
- oDwReadData  out  32  read data, combinational.
- oPending  out  $clog2(WBUF_DEPTH)+1  number of buffered writes not yet retired.
- oEmpty  out  1  oPending == 0.
- oFull  out  1  oPending == WBUF_DEPTH.
- oBusError  out  1  sticky; set by any access outside the window.
- oFwdHits  out  16  performance counter; present only with DBUF_PERF_EN.
- oFullWrites  out  16  performance counter; present only with DBUF_PERF_EN.

## Operation
- Window test: the access is in range when (iDwAddress - BASE_ADDR) < 4·2^ADDR_W (unsigned). Word index is (iDwAddress - BASE_ADDR)[ADDR_W+1:2].
- Out-of-range read: oDwReadData = 0 and oBusError is set.
- Out-of-range write: the write is dropped (no enqueue) and oBusError is set.
- oBusError is cleared only by iRST.
- Buffer entry: {word index, byte enable, data}. The buffer is a circular FIFO with head/tail pointers that wrap modulo WBUF_DEPTH.
- Read data:
  - Start from the array word at the index.
  - Apply every valid entry matching the index, oldest first.
  - Each entry overwrites only the lanes set in its byte enable.
  - oDwReadData is driven whenever iDwReadEnable=1 and the access is in range; otherwise it is 0.
- In-range write, buffer not full: enqueue at the tail. Retirement is not done on this cycle.
- In-range write, buffer full: on the same edge, retire the head into the array and enqueue the new entry. oPending stays at WBUF_DEPTH.
- Idle cycle (both enables low) with buffer not empty: retire the head. Only lanes set in its byte enable are written; then pop.
- Retirement never occurs on a read cycle or a non-full write cycle. The array port is owned by the bus in those cycles.
- Both enables high: treated as a write. Read data is still driven combinationally, forwarded from the pre-enqueue buffer state. The written value becomes visible to reads from the next cycle.
- A write with iDwByteEnable=0 is enqueued and retired but changes no lanes.
- The array is not reset; its contents after power-up are undefined. Buffered entries are discarded on reset (pointers cleared).

## Timing
- Read latency 0: oDwReadData is combinational from the address, enables, array and buffer.
- Write acceptance: captured on the iCLK rising edge of the enable cycle. Forwarded-visible from the next cycle; array-visible after retirement.
- Worst-case retirement delay for an entry is WBUF_DEPTH idle cycles.
- oPending, oEmpty and oFull are registered and update on the edge.
- Reset values: oPending=0, oEmpty=1, oFull=0, oBusError=0, counters 0. oDwReadData is 0 while enables are low.
- iRST mid-operation: pointers, counters and flags clear immediately, with no clock needed. Unretired writes are lost.

## Configuration
- DBUF_PERF_EN defined:
  - oFwdHits increments on each in-range read cycle where at least one buffer entry matched.
  - oFullWrites increments on each write accepted while full.
  - Both saturate at 16'hFFFF and clear on iRST.
- Undefined: both ports and their counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then read BASE_ADDR+0x10 after an idle retire of a write of 32'hDEADBEEF (BE=4'hF) → read returns 32'hDEADBEEF; oPending is 1 after the write edge and 0 after the idle edge.
- Write 32'h11223344 BE=F, then immediately write 32'hAABBCCDD BE=4'b0010 to the same word, then read with no idle cycle between → 32'h1122CC44, with oPending=2.
- Four writes to distinct words with no idle cycles → oFull=1. A fifth write → oFull stays 1, the oldest word is retired into the array, and oFullWrites=1 (with DBUF_PERF_EN). Four idle cycles → oEmpty=1. Reads of all five words return the correct data.
- Read at BASE_ADDR-4 → data 0, oBusError=1. Write at BASE_ADDR+4·2^ADDR_W → oPending unchanged, oBusError stays 1 until iRST.
- Both enables high with word X pending 32'h5 and new data 32'h7 → read returns 32'h5 that cycle and 32'h7 on the next read.
- Assert iRST with oPending=3 between clock edges → oPending=0 and oEmpty=1 immediately. A later read of those words returns the array contents, not the discarded buffered data.

Source files
------------

// File: rtl/data_bus_responder.sv
// data_bus_responder: Dw-bus target owning one data-RAM window, with a posted write buffer
// and same-cycle read forwarding. Optional performance counters are enabled by DBUF_PERF_EN.
`default_nettype none

module data_bus_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          ADDR_W     = 10,
    parameter int          WBUF_DEPTH = 4
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iDwReadEnable,
    input  logic                          iDwWriteEnable,
    input  logic [3:0]                    iDwByteEnable,
    input  logic [31:0]                   iDwAddress,
    input  logic [31:0]                   iDwWriteData,
    output logic [31:0]                   oDwReadData,
    output logic [$clog2(WBUF_DEPTH):0]   oPending,
    output logic                          oEmpty,
    output logic                          oFull,
    output logic                          oBusError
`ifdef DBUF_PERF_EN
   ,output logic [15:0]                   oFwdHits,
    output logic [15:0]                   oFullWrites
`endif
);

    localparam int          c_PTR_W     = $clog2(WBUF_DEPTH);
    localparam int          c_CNT_W     = c_PTR_W + 1;
    localparam int          c_WORDS     = 1 << ADDR_W;
    localparam logic [32:0] c_WIN_BYTES = 33'd4 << ADDR_W;

    logic [31:0]         r_mem   [c_WORDS];
    logic [ADDR_W-1:0]   r_bidx  [WBUF_DEPTH];
    logic [3:0]          r_bbe   [WBUF_DEPTH];
    logic [31:0]         r_bdata [WBUF_DEPTH];

    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_empty;
    logic                r_full;
    logic                r_bus_err;

    logic [31:0]         w_off;
    logic                w_inrange;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_enq;
    logic                w_retire;
    logic                w_oor;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [31:0]         w_merged;
    logic [c_PTR_W-1:0]  w_slot;
`ifdef DBUF_PERF_EN
    logic                w_hit;
    logic [15:0]         r_fwd_hits;
    logic [15:0]         r_full_writes;
`endif

    assign w_off     = iDwAddress - BASE_ADDR;
    assign w_inrange = ({1'b0, w_off} < c_WIN_BYTES);
    assign w_idx     = w_off[ADDR_W+1:2];
    assign w_oor     = (iDwReadEnable || iDwWriteEnable) && !w_inrange;
    assign w_enq     = iDwWriteEnable && w_inrange;

    // The array port is free only on idle cycles, except that a full buffer must make room.
    assign w_retire  = (w_enq && r_full) ||
                       (!iDwReadEnable && !iDwWriteEnable && !r_empty);

    assign w_count_nxt = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_retire);

    always_comb begin
        w_merged = r_mem[w_idx];
        w_slot   = '0;
`ifdef DBUF_PERF_EN
        w_hit    = 1'b0;
`endif
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            w_slot = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (r_bidx[w_slot] == w_idx)) begin
`ifdef DBUF_PERF_EN
                w_hit = 1'b1;
`endif
                for (int n = 0; n < 4; n++) begin
                    if (r_bbe[w_slot][n]) begin
                        w_merged[8*n +: 8] = r_bdata[w_slot][8*n +: 8];
                    end
                end
            end
        end
    end

    assign oDwReadData = (iDwReadEnable && w_inrange) ? w_merged : 32'h0;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_retire) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CNT_W'(WBUF_DEPTH));
            if (w_oor) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: only the pointers decide which slots are live.
    always_ff @(posedge iCLK) begin
        if (w_enq) begin
            r_bidx[r_tail]  <= w_idx;
            r_bbe[r_tail]   <= iDwByteEnable;
            r_bdata[r_tail] <= iDwWriteData;
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_retire && !iRST) begin
            for (int n = 0; n < 4; n++) begin
                if (r_bbe[r_head][n]) begin
                    r_mem[r_bidx[r_head]][8*n +: 8] <= r_bdata[r_head][8*n +: 8];
                end
            end
        end
    end

    assign oPending  = r_count;
    assign oEmpty    = r_empty;
    assign oFull     = r_full;
    assign oBusError = r_bus_err;

`ifdef DBUF_PERF_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_fwd_hits    <= 16'h0;
            r_full_writes <= 16'h0;
        end else begin
            if (iDwReadEnable && w_inrange && w_hit && (r_fwd_hits != 16'hFFFF)) begin
                r_fwd_hits <= r_fwd_hits + 16'h1;
            end
            if (w_enq && r_full && (r_full_writes != 16'hFFFF)) begin
                r_full_writes <= r_full_writes + 16'h1;
            end
        end
    end

    assign oFwdHits    = r_fwd_hits;
    assign oFullWrites = r_full_writes;
`endif

endmodule

`default_nettype wire
